z2_backprop: RTL and testbench

- Backward-pass companion to the z2 forward neuron (2 inputs, 1 output).
- Takes the forward operands (k1, k2, w2_1, w2_2, b2), the forward result z2 and a target t2.
- Computes the output error delta2 = z2 - t2 and the SGD-updated weights and bias, using one shared multiplier under a small FSM with a start/done handshake.
- Results feed the weight registers ahead of the next forward pass.

---
 rtl/z2_backprop.sv | 213 +++++++++++++++++++++
 tb/tb_z2_backprop.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z2_backprop.sv
// ---------------------------------------------------------------------------
// z2_backprop
//
// Backward-pass companion to the z2 forward neuron (2 inputs, 1 output).
// On a start request it latches the forward operands, target and forward
// result, then walks a short FSM that reuses one multiplier to produce the
// output error and the SGD-updated weights and bias:
//   delta2   = z2 - t2                                  (signed Q5.4)
//   w2_x_new = w2_x - ((delta2 * kx) >>> (4 + LR_SHIFT)) (signed Q6.10)
//   b2_new   = b2   - ((delta2 << 6) >>> LR_SHIFT)       (signed Q6.10)
//
// Build option:
//   Z2_BP_SAT_EN  defined   -> 26-bit update results saturate to 16 bits
//                 undefined -> 26-bit update results wrap to 16 bits
//
// Parameter:
//   LR_SHIFT  learning rate = 2^-LR_SHIFT (0..8)
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous active-high reset
//   start     in   1   request pulse, sampled only in IDLE
//   k1, k2    in  16   signed Q6.10 forward inputs
//   w2_1,w2_2 in  16   signed Q6.10 current weights
//   b2        in  16   signed Q6.10 current bias
//   z2        in   8   unsigned Q4.4 forward output
//   t2        in   8   unsigned Q4.4 target
//   busy      out  1   high from the cycle after start is accepted until done
//   done      out  1   one-cycle pulse, results valid from here on
//   delta2    out  9   signed Q5.4 error
//   w2_1_new  out 16   updated weight 1
//   w2_2_new  out 16   updated weight 2
//   b2_new    out 16   updated bias
// ---------------------------------------------------------------------------
module z2_backprop #(
  parameter int unsigned LR_SHIFT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] k1,
  input  logic [15:0] k2,
  input  logic [15:0] w2_1,
  input  logic [15:0] w2_2,
  input  logic [15:0] b2,
  input  logic [7:0]  z2,
  input  logic [7:0]  t2,
  output logic        busy,
  output logic        done,
  output logic [8:0]  delta2,
  output logic [15:0] w2_1_new,
  output logic [15:0] w2_2_new,
  output logic [15:0] b2_new
);

  typedef enum logic [2:0] {
    IDLE,
    DELTA,
    UPD_W1,
    UPD_W2,
    UPD_B,
    DONE
  } state_t;

  state_t             state_q;

  // Operand latches, captured once per operation
  logic signed [15:0] k1_q;
  logic signed [15:0] k2_q;
  logic signed [15:0] w2_1_q;
  logic signed [15:0] w2_2_q;
  logic signed [15:0] b2_q;
  logic [7:0]         z2_q;
  logic [7:0]         t2_q;

  // Registered results and handshake outputs
  logic signed [8:0]  delta2_q;
  logic [15:0]        w2_1_new_q;
  logic [15:0]        w2_2_new_q;
  logic [15:0]        b2_new_q;
  logic               busy_q;
  logic               done_q;

  // Shared datapath
  logic signed [8:0]  delta_d;
  logic signed [15:0] kSel;
  logic signed [15:0] wSel;
  logic signed [24:0] mulA;
  logic signed [24:0] mulB;
  logic signed [24:0] product;
  logic signed [25:0] gradW;
  logic signed [25:0] stepW;
  logic signed [25:0] deltaExt;
  logic signed [25:0] stepB;
  logic signed [25:0] subA;
  logic signed [25:0] subB;
  logic signed [25:0] diff;
  logic [15:0]        result_d;

  // Zero-extend both unsigned Q4.4 values to 9 bits so the difference
  // lands in signed Q5.4 without overflow.
  assign delta_d = {1'b0, z2_q} - {1'b0, t2_q};

  // The single multiplier serves both weight updates; the state picks
  // which input/weight pair feeds it.
  assign kSel = (state_q == UPD_W2) ? k2_q : k1_q;
  assign wSel = (state_q == UPD_W2) ? w2_2_q : w2_1_q;

  // Operands are explicitly sign-extended to the 25-bit product width so
  // the full Q5.4 x Q6.10 product (14 fraction bits) is exact.
  assign mulA    = {{16{delta2_q[8]}}, delta2_q};
  assign mulB    = {{9{kSel[15]}}, kSel};
  assign product = mulA * mulB;

  // Dropping 4 fraction bits returns to Q.10, the extra LR_SHIFT applies
  // the learning rate; arithmetic shift rounds toward -inf.
  assign gradW = {product[24], product};
  assign stepW = gradW >>> (4 + LR_SHIFT);

  // The bias gradient is delta2 itself: Q.4 -> Q.10 is a left shift of 6.
  assign deltaExt = {{17{delta2_q[8]}}, delta2_q};
  assign stepB    = (deltaExt <<< 6) >>> LR_SHIFT;

  // One 26-bit subtractor shared by the three update states
  assign subA = (state_q == UPD_B) ? {{10{b2_q[15]}}, b2_q}
                                   : {{10{wSel[15]}}, wSel};
  assign subB = (state_q == UPD_B) ? stepB : stepW;
  assign diff = subA - subB;

`ifdef Z2_BP_SAT_EN
  // Clamp the wide result into the 16-bit signed range
  always_comb begin
    result_d = 16'(diff);
    if (diff > 26'sd32767) begin
      result_d = 16'h7FFF;
    end else if (diff < -26'sd32768) begin
      result_d = 16'h8000;
    end
  end
`else
  // Keep the low 16 bits (two's-complement wrap)
  assign result_d = 16'(diff);
`endif

  // Control FSM plus all registered outputs. busy/done are derived from
  // the state one cycle late, so busy covers the five cycles after start
  // is accepted and done lands in the cycle after the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k1_q       <= '0;
      k2_q       <= '0;
      w2_1_q     <= '0;
      w2_2_q     <= '0;
      b2_q       <= '0;
      z2_q       <= '0;
      t2_q       <= '0;
      delta2_q   <= '0;
      w2_1_new_q <= '0;
      w2_2_new_q <= '0;
      b2_new_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            k1_q    <= k1;
            k2_q    <= k2;
            w2_1_q  <= w2_1;
            w2_2_q  <= w2_2;
            b2_q    <= b2;
            z2_q    <= z2;
            t2_q    <= t2;
            state_q <= DELTA;
          end
        end
        DELTA: begin
          delta2_q <= delta_d;
          state_q  <= UPD_W1;
        end
        UPD_W1: begin
          w2_1_new_q <= result_d;
          state_q    <= UPD_W2;
        end
        UPD_W2: begin
          w2_2_new_q <= result_d;
          state_q    <= UPD_B;
        end
        UPD_B: begin
          b2_new_q <= result_d;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign delta2   = delta2_q;
  assign w2_1_new = w2_1_new_q;
  assign w2_2_new = w2_2_new_q;
  assign b2_new   = b2_new_q;

endmodule

// File: tb/tb_z2_backprop.sv
// ---------------------------------------------------------------------------
// tb_z2_backprop
//
// Directed self-checking bench for z2_backprop with LR_SHIFT = 3. Each
// scenario task drives its own vectors and compares against hand-computed
// values. Inputs change 1 ns after a rising edge and outputs are sampled at
// that same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_z2_backprop;

  localparam int LR_SHIFT = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] k1;
  logic [15:0] k2;
  logic [15:0] w2_1;
  logic [15:0] w2_2;
  logic [15:0] b2;
  logic [7:0]  z2;
  logic [7:0]  t2;
  logic        busy;
  logic        done;
  logic [8:0]  delta2;
  logic [15:0] w2_1_new;
  logic [15:0] w2_2_new;
  logic [15:0] b2_new;

  int vectors;
  int miscompares;

  z2_backprop #(
    .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .k1       (k1),
    .k2       (k2),
    .w2_1     (w2_1),
    .w2_2     (w2_2),
    .b2       (b2),
    .z2       (z2),
    .t2       (t2),
    .busy     (busy),
    .done     (done),
    .delta2   (delta2),
    .w2_1_new (w2_1_new),
    .w2_2_new (w2_2_new),
    .b2_new   (b2_new)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic driveOperands(input logic [15:0] a1, input logic [15:0] a2,
                               input logic [15:0] v1, input logic [15:0] v2,
                               input logic [15:0] bb, input logic [7:0] zz,
                               input logic [7:0] tt);
    k1   = a1;
    k2   = a2;
    w2_1 = v1;
    w2_2 = v2;
    b2   = bb;
    z2   = zz;
    t2   = tt;
  endtask

  // Garbage on the operand bus after the start cycle must not matter
  task automatic scrambleOperands();
    k1   = 16'($urandom);
    k2   = 16'($urandom);
    w2_1 = 16'($urandom);
    w2_2 = 16'($urandom);
    b2   = 16'($urandom);
    z2   = 8'($urandom);
    t2   = 8'($urandom);
  endtask

  // Called 1 ns after an edge; returns 1 ns after the edge that samples start
  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scrambleOperands();
  endtask

  task automatic waitDone(input int limit, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= limit && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    driveOperands(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_done: got %b expected 0", done);
    end
    vectors++;
    if (delta2 !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_delta2: got %h expected 000", delta2);
    end
    vectors++;
    if (w2_1_new !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_w2_1_new: got %h expected 0000", w2_1_new);
    end
    vectors++;
    if (w2_2_new !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_w2_2_new: got %h expected 0000", w2_2_new);
    end
    vectors++;
    if (b2_new !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_b2_new: got %h expected 0000", b2_new);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // delta=15, g=15*8192=122880, s=960; b step=(15<<6)>>3=120
  task automatic test_nominal();
    int doneCyc;
    int doneCount;
    int busyCount;
    doneCyc   = 0;
    doneCount = 0;
    busyCount = 0;
    driveOperands(16'h2000, 16'h2000, 16'h0066, 16'h0199, 16'hFC00, 8'h2F, 8'h20);
    pulseStart();
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk);
      #1;
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        if (doneCyc == 0) doneCyc = cyc;
      end
    end
    vectors++;
    if (doneCyc !== 5) begin
      miscompares++;
      $display("[TB] FAIL nominal_latency: got %0d expected 5", doneCyc);
    end
    vectors++;
    if (doneCount !== 1) begin
      miscompares++;
      $display("[TB] FAIL nominal_done_pulses: got %0d expected 1", doneCount);
    end
    vectors++;
    if (busyCount !== 5) begin
      miscompares++;
      $display("[TB] FAIL nominal_busy_cycles: got %0d expected 5", busyCount);
    end
    vectors++;
    if (delta2 !== 9'h00F) begin
      miscompares++;
      $display("[TB] FAIL nominal_delta2: got %h expected 00f", delta2);
    end
    vectors++;
    if (w2_1_new !== 16'hFCA6) begin
      miscompares++;
      $display("[TB] FAIL nominal_w2_1_new: got %h expected fca6", w2_1_new);
    end
    vectors++;
    if (w2_2_new !== 16'hFDD9) begin
      miscompares++;
      $display("[TB] FAIL nominal_w2_2_new: got %h expected fdd9", w2_2_new);
    end
    vectors++;
    if (b2_new !== 16'hFB88) begin
      miscompares++;
      $display("[TB] FAIL nominal_b2_new: got %h expected fb88", b2_new);
    end
  endtask

  task automatic test_zero_error();
    int  cyc;
    bit  seen;
    driveOperands(16'h1234, 16'hF00D, 16'hABCD, 16'h4321, 16'h8001, 8'h47, 8'h47);
    pulseStart();
    waitDone(12, cyc, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL zero_done_timeout: got %b expected 1", seen);
    end
    vectors++;
    if (delta2 !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL zero_delta2: got %h expected 000", delta2);
    end
    vectors++;
    if (w2_1_new !== 16'hABCD) begin
      miscompares++;
      $display("[TB] FAIL zero_w2_1_new: got %h expected abcd", w2_1_new);
    end
    vectors++;
    if (w2_2_new !== 16'h4321) begin
      miscompares++;
      $display("[TB] FAIL zero_w2_2_new: got %h expected 4321", w2_2_new);
    end
    vectors++;
    if (b2_new !== 16'h8001) begin
      miscompares++;
      $display("[TB] FAIL zero_b2_new: got %h expected 8001", b2_new);
    end
  endtask

  // delta=-1: g=-1, s=-1 (floor); bias step=(-64)>>>3=-8
  task automatic test_negative_delta();
    int  cyc;
    bit  seen;
    driveOperands(16'h0001, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 8'h00, 8'h01);
    pulseStart();
    waitDone(12, cyc, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL neg_done_timeout: got %b expected 1", seen);
    end
    vectors++;
    if (delta2 !== 9'h1FF) begin
      miscompares++;
      $display("[TB] FAIL neg_delta2: got %h expected 1ff", delta2);
    end
    vectors++;
    if (w2_1_new !== 16'h0101) begin
      miscompares++;
      $display("[TB] FAIL neg_w2_1_new: got %h expected 0101", w2_1_new);
    end
    vectors++;
    if (w2_2_new !== 16'h0200) begin
      miscompares++;
      $display("[TB] FAIL neg_w2_2_new: got %h expected 0200", w2_2_new);
    end
    vectors++;
    if (b2_new !== 16'h0008) begin
      miscompares++;
      $display("[TB] FAIL neg_b2_new: got %h expected 0008", b2_new);
    end
  endtask

  // w1: 32512 - (255*-32768 >>> 7 = -65280) = 97792 -> 0x17E00
  // w2: -32512 - (255*32767 >>> 7 = 65278) = -97790 -> 0x...8202
  // b : 32752 - 2040 = 30712 = 0x77F8 (in range)
  task automatic test_overflow();
    int          cyc;
    bit          seen;
    logic [15:0] expW1;
    logic [15:0] expW2;
`ifdef Z2_BP_SAT_EN
    expW1 = 16'h7FFF;
    expW2 = 16'h8000;
`else
    expW1 = 16'h7E00;
    expW2 = 16'h8202;
`endif
    driveOperands(16'h8000, 16'h7FFF, 16'h7F00, 16'h8100, 16'h7FF0, 8'hFF, 8'h00);
    pulseStart();
    waitDone(12, cyc, seen);
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovf_done_timeout: got %b expected 1", seen);
    end
    vectors++;
    if (delta2 !== 9'h0FF) begin
      miscompares++;
      $display("[TB] FAIL ovf_delta2: got %h expected 0ff", delta2);
    end
    vectors++;
    if (w2_1_new !== expW1) begin
      miscompares++;
      $display("[TB] FAIL ovf_w2_1_new: got %h expected %h", w2_1_new, expW1);
    end
    vectors++;
    if (w2_2_new !== expW2) begin
      miscompares++;
      $display("[TB] FAIL ovf_w2_2_new: got %h expected %h", w2_2_new, expW2);
    end
    vectors++;
    if (b2_new !== 16'h77F8) begin
      miscompares++;
      $display("[TB] FAIL ovf_b2_new: got %h expected 77f8", b2_new);
    end
  endtask

  // Start edge N runs the nominal op; starts at N+2 (busy) and N+5 (DONE
  // state) must be dropped; the start at N+6 (first IDLE) runs the
  // negative-delta op, whose done lands at N+11.
  task automatic test_back_to_back();
    int          doneCount;
    int          firstDone;
    int          secondDone;
    logic        busyAt6;
    logic        busyAt7;
    logic [15:0] w1First;
    logic [15:0] bFirst;
    doneCount  = 0;
    firstDone  = 0;
    secondDone = 0;
    busyAt6    = 1'bx;
    busyAt7    = 1'bx;
    w1First    = 16'hxxxx;
    bFirst     = 16'hxxxx;
    driveOperands(16'h2000, 16'h2000, 16'h0066, 16'h0199, 16'hFC00, 8'h2F, 8'h20);
    pulseStart();
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (cyc == 2 || cyc == 5) begin
        start = 1'b1;
      end else if (cyc == 6) begin
        driveOperands(16'h0001, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 8'h00, 8'h01);
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (cyc == 6) scrambleOperands();
      if (cyc == 6) busyAt6 = busy;
      if (cyc == 7) busyAt7 = busy;
      if (done) begin
        doneCount++;
        if (firstDone == 0) begin
          firstDone = cyc;
          w1First   = w2_1_new;
          bFirst    = b2_new;
        end else if (secondDone == 0) begin
          secondDone = cyc;
        end
      end
    end
    vectors++;
    if (firstDone !== 5) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_done: got %0d expected 5", firstDone);
    end
    vectors++;
    if (secondDone !== 11) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_done: got %0d expected 11", secondDone);
    end
    vectors++;
    if (doneCount !== 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_pulses: got %0d expected 2", doneCount);
    end
    vectors++;
    if (busyAt6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_busy_idle: got %b expected 0", busyAt6);
    end
    vectors++;
    if (busyAt7 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_busy_restart: got %b expected 1", busyAt7);
    end
    vectors++;
    if (w1First !== 16'hFCA6) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_w2_1_new: got %h expected fca6", w1First);
    end
    vectors++;
    if (bFirst !== 16'hFB88) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_b2_new: got %h expected fb88", bFirst);
    end
    vectors++;
    if (w2_1_new !== 16'h0101) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_w2_1_new: got %h expected 0101", w2_1_new);
    end
    vectors++;
    if (delta2 !== 9'h1FF) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_delta2: got %h expected 1ff", delta2);
    end
  endtask

  // Reset is raised during UPD_W2 (the cycle after edge N+2)
  task automatic test_reset_midop();
    int doneCount;
    int cyc;
    bit seen;
    doneCount = 0;
    driveOperands(16'h2000, 16'h2000, 16'h0066, 16'h0199, 16'hFC00, 8'h2F, 8'h20);
    pulseStart();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (delta2 !== 9'h000) begin
      miscompares++;
      $display("[TB] FAIL midreset_delta2: got %h expected 000", delta2);
    end
    vectors++;
    if (w2_1_new !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_w2_1_new: got %h expected 0000", w2_1_new);
    end
    vectors++;
    if (w2_2_new !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_w2_2_new: got %h expected 0000", w2_2_new);
    end
    vectors++;
    if (b2_new !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL midreset_b2_new: got %h expected 0000", b2_new);
    end
    if (done) doneCount++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    vectors++;
    if (doneCount !== 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_no_done: got %0d expected 0", doneCount);
    end
    driveOperands(16'h2000, 16'h2000, 16'h0066, 16'h0199, 16'hFC00, 8'h2F, 8'h20);
    pulseStart();
    waitDone(12, cyc, seen);
    vectors++;
    if (seen !== 1'b1 || cyc !== 5) begin
      miscompares++;
      $display("[TB] FAIL postreset_done: got seen=%b cyc=%0d expected seen=1 cyc=5", seen, cyc);
    end
    vectors++;
    if (w2_1_new !== 16'hFCA6) begin
      miscompares++;
      $display("[TB] FAIL postreset_w2_1_new: got %h expected fca6", w2_1_new);
    end
    vectors++;
    if (w2_2_new !== 16'hFDD9) begin
      miscompares++;
      $display("[TB] FAIL postreset_w2_2_new: got %h expected fdd9", w2_2_new);
    end
    vectors++;
    if (b2_new !== 16'hFB88) begin
      miscompares++;
      $display("[TB] FAIL postreset_b2_new: got %h expected fb88", b2_new);
    end
  endtask

  // Scenario sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    driveOperands(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0);
    test_reset();
    test_nominal();
    test_zero_error();
    test_negative_delta();
    test_overflow();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
